// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared types and sizing helpers for the digit-serial arithmetic units
package serial_arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [8:0] DIGIT_LEGAL_MASK = 9'b1_0001_0110;

    function automatic bit digit_legal(int d);
        return d inside {1, 2, 4, 8};
    endfunction

    function automatic int num_digits(int w, int d);
        return w / d;
    endfunction

    function automatic int cnt_width(int w, int d);
        return (w / d) > 1 ? $clog2(w / d) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_onebit.sv
// full_subtractor_onebit: one-bit full subtractor, d = a - b - bi with borrow-out bo
module full_subtractor_onebit (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial A - B - Bin, DIGIT bits per clock, LSB digit first
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (!digit_legal(DIGIT) || WIDTH % DIGIT != 0) begin : g_bad_cfg
        $error("serial_subtractor: illegal WIDTH/DIGIT combination");
    end

    state_t           state, next;
    logic [WIDTH-1:0] a_sr, b_sr, nres;
    logic [CW-1:0]    cnt;
    logic             borrow, a_msb, b_msb, accept, last;
    logic [DIGIT:0]   bc;
    logic [DIGIT-1:0] dig;

    assign accept = start && state != RUN;
    assign last   = cnt == CW'(N - 1);
    assign bc[0]  = borrow;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fs
        full_subtractor_onebit u_fs (
            .a (a_sr[i]),
            .b (b_sr[i]),
            .bi(bc[i]),
            .d (dig[i]),
            .bo(bc[i+1])
        );
    end

    // a_sr doubles as the result register: result digits enter at the top as operand digits leave the bottom
    assign nres = WIDTH'({dig, a_sr} >> DIGIT);

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= next;

    always_comb
        next = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            Ovf    <= 1'b0;
        end else if (accept) begin
            a_sr   <= A;
            b_sr   <= B;
            cnt    <= '0;
            borrow <= Bin;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
        end else if (state == RUN) begin
            a_sr   <= nres;
            b_sr   <= b_sr >> DIGIT;
            cnt    <= cnt + CW'(1);
            borrow <= bc[DIGIT];
            if (last) begin
                Diff <= nres;
                Bout <= bc[DIGIT];
                Ovf  <= (a_msb != b_msb) && (nres[WIDTH-1] != a_msb);
            end
        end
    end

endmodule
